// File: rtl/seg_disp_arbiter_if.sv
// ---------------------------------------------------------------------------
// seg_disp_arbiter_if
// Write handshake bundle between the two display requesters and the
// seven-segment display arbiter.
//   a_req/a_data/a_ack : source A (CPU store), req held high until ack
//   b_req/b_data/b_ack : source B (debug monitor), same protocol
//   data packing       : [23:20] -> led1 ... [3:0] -> led6
// Modports:
//   master : requester side (drives req/data, observes ack)
//   slave  : arbiter side (observes req/data, drives ack)
// ---------------------------------------------------------------------------
interface seg_disp_arbiter_if;
    logic        a_req;
    logic [23:0] a_data;
    logic        a_ack;
    logic        b_req;
    logic [23:0] b_data;
    logic        b_ack;

    modport master (
        output a_req, a_data, b_req, b_data,
        input  a_ack, b_ack
    );

    modport slave (
        input  a_req, a_data, b_req, b_data,
        output a_ack, b_ack
    );
endinterface

// File: rtl/seg_disp_arbiter.sv
// ---------------------------------------------------------------------------
// seg_disp_arbiter
// Owns the six 4-bit digit registers feeding a six-digit seven-segment
// scanner. Two sources (A: CPU store, B: debug monitor) write a full
// six-nibble value through a req/ack handshake. Round-robin arbitration
// with a minimum hold time keeps a granted value on the display for
// HOLD_CYCLES before the other source may take over.
// Ports:
//   CLK        : system clock, rising edge
//   reset      : synchronous, active-high
//   bus        : slave side of the A/B write handshake
//   freeze     : when high, no request is accepted
//   led1..led6 : registered digit values
//   owner      : 00 none since reset, 01 A, 10 B (last accepted source)
//   hold_busy  : high while the hold window is running
// ---------------------------------------------------------------------------
module seg_disp_arbiter #(
    parameter int HOLD_CYCLES = 1024,
    parameter int CW          = 11
) (
    input  logic                     CLK,
    input  logic                     reset,
    seg_disp_arbiter_if.slave        bus,
    input  logic                     freeze,
    output logic [3:0]               led1,
    output logic [3:0]               led2,
    output logic [3:0]               led3,
    output logic [3:0]               led4,
    output logic [3:0]               led5,
    output logic [3:0]               led6,
    output logic [1:0]               owner,
    output logic                     hold_busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [1:0]    OWN_NONE  = 2'b00;
    localparam logic [1:0]    OWN_A     = 2'b01;
    localparam logic [1:0]    OWN_B     = 2'b10;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    state_t        state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [23:0]   digits_q,  digits_d;
    logic [1:0]    owner_q,   owner_d;
    logic          last_b_q,  last_b_d;   // 1: B was granted last, so A wins a tie
    logic          a_ack_q,   a_ack_d;
    logic          b_ack_q,   b_ack_d;

    logic a_elig;
    logic b_elig;
    logic take_a;
    logic take_b;

    // A request seen during its own ack cycle is the tail of the previous
    // handshake, not a new write.
    assign a_elig = bus.a_req & ~a_ack_q;
    assign b_elig = bus.b_req & ~b_ack_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        owner_d  = owner_q;
        last_b_d = last_b_q;
        a_ack_d  = 1'b0;
        b_ack_d  = 1'b0;
        take_a   = 1'b0;
        take_b   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!freeze && (a_elig || b_elig)) begin
                    if (a_elig && (!b_elig || last_b_q)) begin
                        take_a = 1'b1;
                    end else begin
                        take_b = 1'b1;
                    end
                    cnt_d   = HOLD_LOAD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // The hold window always runs to completion; freeze and owner
                // refreshes neither pause nor reload it.
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
                // Only the current owner may update the display during hold.
                take_a = !freeze && a_elig && (owner_q == OWN_A);
                take_b = !freeze && b_elig && (owner_q == OWN_B);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take_a) begin
            digits_d = bus.a_data;
            owner_d  = OWN_A;
            last_b_d = 1'b0;
            a_ack_d  = 1'b1;
        end else if (take_b) begin
            digits_d = bus.b_data;
            owner_d  = OWN_B;
            last_b_d = 1'b1;
            b_ack_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            digits_q <= '0;
            owner_q  <= OWN_NONE;
            last_b_q <= 1'b1;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            owner_q  <= owner_d;
            last_b_q <= last_b_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
        end
    end

    assign bus.a_ack = a_ack_q;
    assign bus.b_ack = b_ack_q;
    assign led1      = digits_q[23:20];
    assign led2      = digits_q[19:16];
    assign led3      = digits_q[15:12];
    assign led4      = digits_q[11:8];
    assign led5      = digits_q[7:4];
    assign led6      = digits_q[3:0];
    assign owner     = owner_q;
    assign hold_busy = (state_q == S_HOLD);

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seg_disp_arbiter
// Directed scenarios plus randomized traffic for seg_disp_arbiter with a
// short hold window. A behavioural model tracks the display contents, the
// owner, the last grant and the number of hold cycles still to run, and is
// compared against the DUT after every clock edge.
// ---------------------------------------------------------------------------
module tb_seg_disp_arbiter;

    localparam int HOLD = 4;

    logic        CLK = 1'b0;
    logic        reset;
    logic        freeze;
    logic [3:0]  led1, led2, led3, led4, led5, led6;
    logic [1:0]  owner;
    logic        hold_busy;
    logic [23:0] leds;

    int n_cmp = 0;
    int n_err = 0;

    seg_disp_arbiter_if bus();

    seg_disp_arbiter #(.HOLD_CYCLES(HOLD), .CW(3)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .bus       (bus.slave),
        .freeze    (freeze),
        .led1      (led1),
        .led2      (led2),
        .led3      (led3),
        .led4      (led4),
        .led5      (led5),
        .led6      (led6),
        .owner     (owner),
        .hold_busy (hold_busy)
    );

    always #5 CLK = ~CLK;

    assign leds = {led1, led2, led3, led4, led5, led6};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [23:0] m_led;
    logic [1:0]  m_owner;
    logic [1:0]  m_last;
    logic        m_acka, m_ackb;
    int          m_left;     // hold cycles still to be shown as busy
    logic        m_ok = 1'b0;

    always @(posedge CLK) begin
        logic ea, eb, na, nb;
        if (reset) begin
            m_led = '0; m_owner = 2'd0; m_last = 2'd2;
            m_acka = 1'b0; m_ackb = 1'b0; m_left = 0; m_ok = 1'b1;
        end else if (m_ok) begin
            ea = bus.a_req && !m_acka;
            eb = bus.b_req && !m_ackb;
            na = 1'b0; nb = 1'b0;
            if (m_left == 0) begin
                if (!freeze && (ea || eb)) begin
                    if (ea && (!eb || m_last == 2'd2)) na = 1'b1;
                    else nb = 1'b1;
                    m_left = HOLD;
                end
            end else begin
                if (!freeze && m_owner == 2'd1 && ea) na = 1'b1;
                if (!freeze && m_owner == 2'd2 && eb) nb = 1'b1;
                m_left = m_left - 1;
            end
            if (na) begin m_led = bus.a_data; m_owner = 2'd1; m_last = 2'd1; end
            if (nb) begin m_led = bus.b_data; m_owner = 2'd2; m_last = 2'd2; end
            m_acka = na;
            m_ackb = nb;
        end
        #1;
        if (m_ok) begin
            chk("model_cycle",
                {3'b0, bus.a_ack, bus.b_ack, hold_busy, owner, leds},
                {3'b0, m_acka, m_ackb, (m_left > 0), m_owner, m_led});
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        reset = 1'b1;
        bus.a_req = 1'b0; bus.b_req = 1'b0; freeze = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset_leds", {8'b0, leds}, 32'h0);
        chk("reset_owner", {30'b0, owner}, 32'h0);
        chk("reset_hold", {31'b0, hold_busy}, 32'h0);
        chk("reset_acks", {30'b0, bus.a_ack, bus.b_ack}, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        int n;
        logic [1:0] seen;
        logic [1:0] seq [4];

        bus.a_data = '0; bus.b_data = '0;
        do_reset();

        // First write from A and B waiting behind the hold window.
        bus.a_req = 1'b1; bus.a_data = 24'h123456;
        @(negedge CLK);
        chk("t1_a_ack", {31'b0, bus.a_ack}, 32'h1);
        chk("t1_leds", {8'b0, leds}, 32'h123456);
        chk("t1_owner", {30'b0, owner}, 32'h1);
        chk("t1_hold", {31'b0, hold_busy}, 32'h1);
        bus.a_req = 1'b0;
        bus.b_req = 1'b1; bus.b_data = 24'h00000F;
        cnt = 0;
        while (!bus.b_ack && cnt < 20) begin
            @(negedge CLK);
            cnt++;
            if (cnt == 1) chk("t1_a_ack_pulse", {31'b0, bus.a_ack}, 32'h0);
        end
        chk("t2_b_wait", cnt, 5);
        chk("t2_leds", {8'b0, leds}, 32'h00000F);
        chk("t2_owner", {30'b0, owner}, 32'h2);
        bus.b_req = 1'b0;

        // Simultaneous requests alternate owners.
        do_reset();
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        bus.a_data = 24'hAAAAAA; bus.b_data = 24'hBBBBBB;
        seen = 2'd0; n = 0; cnt = 0;
        while (n < 4 && cnt < 100) begin
            @(negedge CLK);
            cnt++;
            if (bus.a_ack) bus.a_data = 24'($urandom);
            if (bus.b_ack) bus.b_data = 24'($urandom);
            if (owner != seen) begin
                seq[n] = owner;
                n++;
                seen = owner;
            end
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        chk("t3_grants", n, 4);
        chk("t3_order", {24'b0, seq[0], seq[1], seq[2], seq[3]}, 32'b01_10_01_10);

        // Owner refresh does not extend the hold window.
        do_reset();
        bus.a_req = 1'b1; bus.a_data = 24'h111111;
        @(negedge CLK);
        chk("t4_first_ack", {31'b0, bus.a_ack}, 32'h1);
        bus.a_req = 1'b0;
        @(negedge CLK);
        bus.a_req = 1'b1; bus.a_data = 24'hABCDEF;
        @(negedge CLK);
        chk("t4_refresh_ack", {31'b0, bus.a_ack}, 32'h1);
        chk("t4_refresh_leds", {8'b0, leds}, 32'hABCDEF);
        bus.a_req = 1'b0;
        @(negedge CLK);
        chk("t4_hold_last", {31'b0, hold_busy}, 32'h1);
        @(negedge CLK);
        chk("t4_hold_end", {31'b0, hold_busy}, 32'h0);

        // Freeze blocks acceptance.
        freeze = 1'b1;
        bus.a_req = 1'b1; bus.a_data = 24'h654321;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("t5_frozen", {7'b0, bus.a_ack, leds}, {8'b0, 24'hABCDEF});
        end
        freeze = 1'b0;
        @(negedge CLK);
        chk("t5_release_ack", {31'b0, bus.a_ack}, 32'h1);
        chk("t5_release_leds", {8'b0, leds}, 32'h654321);
        bus.a_req = 1'b0;

        // Reset in the middle of a hold with B pending.
        bus.b_req = 1'b1; bus.b_data = 24'hABC123;
        @(negedge CLK);
        chk("t6_b_waits", {31'b0, bus.b_ack}, 32'h0);
        reset = 1'b1;
        @(negedge CLK);
        chk("t6_rst_state", {3'b0, bus.a_ack, bus.b_ack, hold_busy, owner, leds}, 32'h0);
        reset = 1'b0;
        @(negedge CLK);
        chk("t6_b_ack", {31'b0, bus.b_ack}, 32'h1);
        chk("t6_leds", {8'b0, leds}, 32'hABC123);
        chk("t6_owner", {30'b0, owner}, 32'h2);
        bus.b_req = 1'b0;

        // Randomized traffic obeying the handshake; the model checks each cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            reset = ($urandom_range(0, 299) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            if (!bus.a_req || bus.a_ack || reset) begin
                bus.a_req = ($urandom_range(0, 2) == 0);
                bus.a_data = 24'($urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                bus.a_data = 24'($urandom);
            end
            if (!bus.b_req || bus.b_ack || reset) begin
                bus.b_req = ($urandom_range(0, 2) == 0);
                bus.b_data = 24'($urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                bus.b_data = 24'($urandom);
            end
        end
        reset = 1'b0;
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
